wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
  CLK  in  1  single clock, rising edge.
  RST  in  1  synchronous, active-high reset.
  ValidM  in  1  MEM/WB slot holds a real instruction.
  RegWriteM  in  1  instruction writes the register file.
  MemtoRegM  in  1  write data comes from memory.
  JumpLinkM  in  1  instruction is jal (link write).
  HaltM  in  1  instruction is the 32'hffffffff end-of-program sentinel.
  WriteRegM  in  5  destination register address.
  ALUOutM  in  32  ALU result.
  ReadDataM  in  32  memory load data.
  PCPlus4M  in  32  PC+4 of the instruction.
  StallW  in  1  hold the MEM/WB register.
  FlushW  in  1  replace incoming slot with a bubble.
  RegWriteW  out  1  register-file write enable to decode stage.
  wb_addr  out  5  register-file write address.
  wb_data  out  32  register-file write data.
  retire_count  out  32  retired-instruction counter.
  halt_done  out  1  sentinel has reached writeback.
REQ-002 SHALL use one clock, CLK; reset RST SHALL be synchronous and active-high.

Function
REQ-003 All outputs SHALL be registered, update only on CLK rising edge, and stay stable for the full following cycle.
REQ-004 Capture priority per edge: RST > halted > FlushW > StallW > normal capture.
REQ-005 Normal capture (valid slot): wb_data = PCPlus4M if JumpLinkM; else ReadDataM if MemtoRegM; else ALUOutM.
REQ-006 wb_addr SHALL be 5'd31 when JumpLinkM=1, else WriteRegM.
REQ-007 RegWriteW SHALL be 1 only if ValidM & (RegWriteM | JumpLinkM) & HaltM=0 & selected address != 0.
REQ-008 ValidM=0 or FlushW=1 SHALL capture a bubble: RegWriteW=0; wb_addr, wb_data hold previous values.
REQ-009 StallW=1 (no flush) SHALL hold all outputs and retire_count unchanged.
REQ-010 retire_count SHALL increment by 1 on each capture of a valid, non-flushed, non-halt instruction (including non-writing ones, e.g. sw, beq); it SHALL saturate at 32'hffffffff.
REQ-011 State machine, two states: RUN (reset state) and HALTED.
REQ-012 RUN -> HALTED when a valid, non-flushed slot with HaltM=1 is captured; that edge sets halt_done=1, RegWriteW=0, and does not increment retire_count.
REQ-013 HALTED is terminal until RST: halt_done=1, RegWriteW=0, retire_count frozen, all M-side inputs ignored.
REQ-014 A stalled sentinel (StallW=1 with HaltM=1) SHALL NOT enter HALTED until captured.
REQ-015 ValidM=0 with HaltM=1 SHALL be ignored.

Reset
REQ-016 On RST at an edge: RegWriteW=0, wb_addr=0, wb_data=0, retire_count=0, halt_done=0, state=RUN, regardless of StallW, FlushW, or current state.
REQ-017 RST asserted mid-stall or while HALTED SHALL fully restart; the first edge after RST deasserts SHALL perform normal capture.

Structure
REQ-018 Shared package wb_pkg SHALL hold the state enum (RUN, HALTED), REG_ZERO=5'd0, REG_RA=5'd31, and the sentinel constant 32'hffffffff.
REQ-019 The data/address selection of REQ-005/006 SHALL be one combinational sub-module, wb_select; all state lives in wb_stage.

Verification
REQ-020 Bench SHALL cover:
  - add: ValidM=1, RegWriteM=1, WriteRegM=8, ALUOutM=32'h5 -> next edge: RegWriteW=1, wb_addr=8, wb_data=5, retire_count=1.
  - lw then jal: ReadDataM=32'hdead_beef with MemtoRegM=1, WriteRegM=9 -> wb_data=32'hdeadbeef; jal with PCPlus4M=32'h40 -> wb_addr=31, wb_data=32'h40, RegWriteW=1.
  - $0 target: RegWriteM=1, WriteRegM=0, ALUOutM=7 -> RegWriteW=0, retire_count still increments.
  - Stall 3 cycles, then flush with valid add in slot -> outputs and count held 3 cycles; flush edge gives RegWriteW=0, count unchanged.
  - Sentinel after 4 instructions -> halt_done=1, retire_count=4; further valid writes -> RegWriteW stays 0; RST -> all outputs 0, state RUN.
  - Saturation: retire_count forced near 32'hffffffff, 2 valid captures -> stays 32'hffffffff.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: FSM states and fixed register numbers.
package wb_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_RA   = 5'd31;
    localparam logic [31:0] SENTINEL = 32'hffff_ffff;

endpackage

// File: rtl/wb_select.sv
// Writeback mux: picks the destination register and the write data for one MEM/WB slot.
module wb_select
    import wb_pkg::*;
(
    input  logic        i_jump_link,
    input  logic        i_mem_to_reg,
    input  logic [4:0]  i_write_reg,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_read_data,
    input  logic [31:0] i_pc_plus4,
    output logic [4:0]  o_addr,
    output logic [31:0] o_data
);

    always_comb begin
        o_addr = i_jump_link ? REG_RA : i_write_reg;
        if (i_jump_link)
            o_data = i_pc_plus4;
        else if (i_mem_to_reg)
            o_data = i_read_data;
        else
            o_data = i_alu_out;
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register with retire counter and end-of-program halt detection.
module wb_stage
    import wb_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        JumpLinkM,
    input  logic        HaltM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] ReadDataM,
    input  logic [31:0] PCPlus4M,
    input  logic        StallW,
    input  logic        FlushW,
    output logic        RegWriteW,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] retire_count,
    output logic        halt_done
);

    wb_state_t   r_state, w_state_next;
    logic        r_we, w_we_next;
    logic [4:0]  r_addr, w_addr_next;
    logic [31:0] r_data, w_data_next;
    logic [31:0] r_retire_count, w_cnt_next;
    logic        r_halt, w_halt_next;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_take;

    wb_select u_select (
        .i_jump_link  (JumpLinkM),
        .i_mem_to_reg (MemtoRegM),
        .i_write_reg  (WriteRegM),
        .i_alu_out    (ALUOutM),
        .i_read_data  (ReadDataM),
        .i_pc_plus4   (PCPlus4M),
        .o_addr       (w_sel_addr),
        .o_data       (w_sel_data)
    );

    // A slot is taken only when it is real and neither flushed nor stalled.
    assign w_take = ValidM && !FlushW && !StallW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= RUN;
            r_we           <= 1'b0;
            r_addr         <= REG_ZERO;
            r_data         <= '0;
            r_retire_count <= '0;
            r_halt         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_we           <= w_we_next;
            r_addr         <= w_addr_next;
            r_data         <= w_data_next;
            r_retire_count <= w_cnt_next;
            r_halt         <= w_halt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == RUN && w_take && HaltM)
            w_state_next = HALTED;
    end

    always_comb begin
        w_we_next   = r_we;
        w_addr_next = r_addr;
        w_data_next = r_data;
        w_cnt_next  = r_retire_count;
        w_halt_next = r_halt;
        if (r_state == HALTED) begin
            w_we_next   = 1'b0;
            w_halt_next = 1'b1;
        end else if (FlushW || (!StallW && !ValidM)) begin
            w_we_next = 1'b0;
        end else if (w_take && HaltM) begin
            w_we_next   = 1'b0;
            w_halt_next = 1'b1;
        end else if (w_take) begin
            w_we_next   = (RegWriteM || JumpLinkM) && (w_sel_addr != REG_ZERO);
            w_addr_next = w_sel_addr;
            w_data_next = w_sel_data;
            if (r_retire_count != SENTINEL)
                w_cnt_next = r_retire_count + 32'd1;
        end
    end

    assign RegWriteW    = r_we;
    assign wb_addr      = r_addr;
    assign wb_data      = r_data;
    assign retire_count = r_retire_count;
    assign halt_done    = r_halt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with hand-computed expectations.
module tb_wb_stage;
    import wb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, ValidM, RegWriteM, MemtoRegM, JumpLinkM, HaltM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
    logic        StallW, FlushW;
    logic        RegWriteW;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, retire_count;
    logic        halt_done;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    wb_stage dut (
        .CLK(CLK), .RST(RST), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .JumpLinkM(JumpLinkM), .HaltM(HaltM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .StallW(StallW), .FlushW(FlushW),
        .RegWriteW(RegWriteW), .wb_addr(wb_addr), .wb_data(wb_data),
        .retire_count(retire_count), .halt_done(halt_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] c, input logic h);
        chk({tag, ".we"},   {31'd0, RegWriteW}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, wb_addr},   {27'd0, a});
        chk({tag, ".data"}, wb_data, d);
        chk({tag, ".cnt"},  retire_count, c);
        chk({tag, ".halt"}, {31'd0, halt_done}, {31'd0, h});
    endtask

    task automatic instr(input logic v, input logic rw, input logic m2r, input logic jl,
                         input logic hlt, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] pc);
        ValidM = v; RegWriteM = rw; MemtoRegM = m2r; JumpLinkM = jl; HaltM = hlt;
        WriteRegM = wr; ALUOutM = alu; ReadDataM = rd; PCPlus4M = pc;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; StallW = 1'b0; FlushW = 1'b0;
        instr(1, 1, 0, 0, 0, 5'd7, 32'h1234, 32'h0, 32'h0);
        step();
        step();
        chk_all("reset", 0, 5'd0, 32'h0, 32'd0, 0);

        RST = 1'b0;
        instr(1, 1, 0, 0, 0, 5'd8, 32'h5, 32'h0, 32'h0);
        step();
        chk_all("add", 1, 5'd8, 32'h5, 32'd1, 0);

        instr(1, 1, 1, 0, 0, 5'd9, 32'h77, 32'hdead_beef, 32'h0);
        step();
        chk_all("lw", 1, 5'd9, 32'hdead_beef, 32'd2, 0);

        instr(1, 0, 0, 1, 0, 5'd5, 32'h11, 32'h22, 32'h40);
        step();
        chk_all("jal", 1, 5'd31, 32'h40, 32'd3, 0);

        instr(1, 1, 0, 0, 0, 5'd0, 32'h7, 32'h0, 32'h0);
        step();
        chk("zero.we",  {31'd0, RegWriteW}, 32'd0);
        chk("zero.cnt", retire_count, 32'd4);

        StallW = 1'b1;
        instr(1, 1, 0, 0, 0, 5'd3, 32'h33, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 0, 5'd0, 32'h7, 32'd4, 0);
        end
        StallW = 1'b0; FlushW = 1'b1;
        step();
        chk_all("flush", 0, 5'd0, 32'h7, 32'd4, 0);
        FlushW = 1'b0;

        instr(0, 1, 0, 0, 0, 5'd6, 32'h66, 32'h0, 32'h0);
        step();
        chk_all("bubble", 0, 5'd0, 32'h7, 32'd4, 0);

        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr(1, 1, 0, 0, 0, 5'(i + 1), 32'(i), 32'h0, 32'h0);
            step();
        end
        chk_all("four", 1, 5'd4, 32'h3, 32'd4, 0);

        StallW = 1'b1;
        instr(1, 0, 0, 0, 1, 5'd0, SENTINEL, 32'h0, 32'h0);
        step();
        chk_all("stall_sent", 1, 5'd4, 32'h3, 32'd4, 0);
        StallW = 1'b0;

        instr(0, 0, 0, 0, 1, 5'd0, SENTINEL, 32'h0, 32'h0);
        step();
        chk_all("inv_sent", 0, 5'd4, 32'h3, 32'd4, 0);

        instr(1, 0, 0, 0, 1, 5'd0, SENTINEL, 32'h0, 32'h0);
        step();
        chk_all("halt", 0, 5'd4, 32'h3, 32'd4, 1);

        instr(1, 1, 0, 0, 0, 5'd10, 32'haa, 32'h0, 32'h0);
        step();
        chk_all("halted", 0, 5'd4, 32'h3, 32'd4, 1);

        RST = 1'b1; StallW = 1'b1;
        step();
        chk_all("rst_halt", 0, 5'd0, 32'h0, 32'd0, 0);
        RST = 1'b0; StallW = 1'b0;
        instr(1, 1, 0, 0, 0, 5'd12, 32'h99, 32'h0, 32'h0);
        step();
        chk_all("restart", 1, 5'd12, 32'h99, 32'd1, 0);

        @(negedge CLK);
        force dut.r_retire_count = 32'hffff_fffe;
        #1;
        release dut.r_retire_count;
        instr(1, 1, 0, 0, 0, 5'd13, 32'h1, 32'h0, 32'h0);
        step();
        chk("sat1", retire_count, 32'hffff_ffff);
        step();
        chk("sat2", retire_count, 32'hffff_ffff);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
